sw_submit: RTL and testbench

SW_SUBMIT -- requirements
Module: sw_submit

---
 rtl/sw_submit_pkg.sv | 25 ++
 rtl/sw_submit_sync_debounce.sv | 102 ++++++++++
 rtl/sw_submit.sv | 114 +++++++++++
 tb/tb_sw_submit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_submit_pkg.sv
// sw_submit_pkg
// Shared definitions for the switch/submit peripheral. The LED and address
// decoder blocks use the same state enum and read-selector codes.
//   deb_state_t  : button debounce FSM states
//   SW_*         : swAddr read-selector codes
//   deb_cnt_w()  : width of a counter that must hold cycles-1
package sw_submit_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW = 2'd0,
      CHK_HIGH = 2'd1,
      HIGH     = 2'd2,
      CHK_LOW  = 2'd3
   } deb_state_t;

   localparam logic [1:0] SW_LO     = 2'b00;
   localparam logic [1:0] SW_LO_ALT = 2'b01;
   localparam logic [1:0] SW_HI     = 2'b10;
   localparam logic [1:0] SW_STAT   = 2'b11;

   function automatic int deb_cnt_w(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/sw_submit_sync_debounce.sv
// sync_debounce
// Two-flop synchronizer followed by a debounce FSM for one bouncy input.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   IDLE_LOW | level is 0, input seen low
//   CHK_HIGH | level is 0, input high, counting stable cycles
//   HIGH     | level is 1, input seen high
//   CHK_LOW  | level is 1, input low, counting stable cycles
//
// Ports:
//   clock   in   system clock
//   reset_n in   asynchronous active-low reset
//   raw     in   asynchronous raw input
//   level   out  debounced level (registered, 1 in HIGH and CHK_LOW)
//   pulse   out  one-cycle strobe after the CHK_HIGH -> HIGH transition
module sync_debounce
   import sw_submit_pkg::*;
#(
   parameter int DEB_CYCLES = 20000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic pulse
);

   localparam int CNT_W = deb_cnt_w(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             s1;
   logic             s2;
   deb_state_t       state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE_LOW;
         cnt   <= '0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else begin
         pulse <= 1'b0;
         case (state)
            IDLE_LOW: begin
               if (s2) begin
                  state <= CHK_HIGH;
                  cnt   <= '0;
               end
            end
            CHK_HIGH: begin
               if (!s2) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= HIGH;
                  cnt   <= '0;
                  level <= 1'b1;
                  pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HIGH: begin
               if (!s2) begin
                  state <= CHK_LOW;
                  cnt   <= '0;
               end
            end
            CHK_LOW: begin
               if (s2) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
                  level <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE_LOW;
               cnt   <= '0;
               level <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/sw_submit.sv
// sw_submit
// Board switch snapshot peripheral. The switch vector is synchronized and
// debounced; a debounced press of the submit button captures the stable
// switch value, which the CPU reads back through a small register window.
//
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   sw_raw      in   raw board switches (asynchronous)
//   submit_raw  in   raw submit button (asynchronous, bouncy)
//   SwitchCtrl  in   address decoder select
//   ioRead      in   CPU I/O read strobe
//   swAddr      in   read selector (low half / high byte / status)
//   read_data   out  combinational CPU read data
//   submit      out  debounced submit level
//   submit_pulse out one-cycle strobe on debounced submit rise
//   sw_valid    out  snapshot taken and not yet read
module sw_submit
   import sw_submit_pkg::*;
#(
   parameter int DEB_CYCLES = 20000,
   parameter int SW_WIDTH   = 24
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [SW_WIDTH-1:0] sw_raw,
   input  logic                submit_raw,
   input  logic                SwitchCtrl,
   input  logic                ioRead,
   input  logic [1:0]          swAddr,
   output logic [15:0]         read_data,
   output logic                submit,
   output logic                submit_pulse,
   output logic                sw_valid
);

   localparam int SCNT_W = deb_cnt_w(DEB_CYCLES);
   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(DEB_CYCLES - 1);

   logic [SW_WIDTH-1:0] sw_s1;
   logic [SW_WIDTH-1:0] sw_s2;
   logic [SW_WIDTH-1:0] sw_prev;
   logic [SW_WIDTH-1:0] sw_stable;
   logic [SW_WIDTH-1:0] sw_snap;
   logic [SCNT_W-1:0]   scnt;
   logic                rd_en;
   logic                rd_clr;

   sync_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_btn (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (submit_raw),
      .level   (submit),
      .pulse   (submit_pulse)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= sw_raw;
         sw_s2 <= sw_s1;
      end
   end

   // Any change restarts the count; once the count is reached it saturates
   // and sw_stable keeps tracking the unchanged value.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sw_prev   <= '0;
         sw_stable <= '0;
         scnt      <= '0;
      end else if (sw_s2 != sw_prev) begin
         sw_prev <= sw_s2;
         scnt    <= '0;
      end else if (scnt == SCNT_LAST) begin
         sw_stable <= sw_prev;
      end else begin
         scnt <= scnt + SCNT_W'(1);
      end
   end

   assign rd_en  = SwitchCtrl & ioRead;
   assign rd_clr = rd_en && (swAddr == SW_LO);

   // A capture on the same edge as a consuming read keeps the new snapshot valid.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sw_snap  <= '0;
         sw_valid <= 1'b0;
      end else if (submit_pulse) begin
         sw_snap  <= sw_stable;
         sw_valid <= 1'b1;
      end else if (rd_clr) begin
         sw_valid <= 1'b0;
      end
   end

   always_comb begin
      read_data = 16'h0000;
      if (rd_en) begin
         case (swAddr)
            SW_LO, SW_LO_ALT: read_data = sw_snap[15:0];
            SW_HI:            read_data = {8'h00, sw_snap[23:16]};
            SW_STAT:          read_data = {15'b0, sw_valid};
            default:          read_data = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_sw_submit.sv
// tb_sw_submit
// Directed scenarios with literal expectations, then randomized stimulus,
// all compared every cycle against a run-length reference model.
module tb_sw_submit;

   localparam int DEB = 4;

   logic        clock;
   logic        reset_n;
   logic [23:0] sw_raw;
   logic        submit_raw;
   logic        SwitchCtrl;
   logic        ioRead;
   logic [1:0]  swAddr;
   logic [15:0] read_data;
   logic        submit;
   logic        submit_pulse;
   logic        sw_valid;

   int n_checks = 0;
   int n_fail   = 0;

   sw_submit #(
      .DEB_CYCLES (DEB),
      .SW_WIDTH   (24)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .sw_raw       (sw_raw),
      .submit_raw   (submit_raw),
      .SwitchCtrl   (SwitchCtrl),
      .ioRead       (ioRead),
      .swAddr       (swAddr),
      .read_data    (read_data),
      .submit       (submit),
      .submit_pulse (submit_pulse),
      .sw_valid     (sw_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the button level flips after DEB+1 consecutive
   // synchronized samples that disagree with it; the switch value becomes
   // stable after DEB+1 identical consecutive synchronized samples.
   logic        m_s1, m_s2, m_level, m_pulse, m_valid;
   int          m_run, m_srun;
   logic [23:0] m_v1, m_v2, m_last, m_stable, m_snap;

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_valid = 0;
      m_run = 0; m_srun = 0;
      m_v1 = 0; m_v2 = 0; m_last = 0; m_stable = 0; m_snap = 0;
   endtask

   task automatic model_step();
      logic        s;
      logic [23:0] sv;
      logic        old_pulse;
      logic [23:0] old_stable;
      logic        clr;
      if (!reset_n) begin
         model_reset();
         return;
      end
      s  = m_s2;  m_s2 = m_s1;  m_s1 = submit_raw;
      sv = m_v2;  m_v2 = m_v1;  m_v1 = sw_raw;
      old_pulse  = m_pulse;
      old_stable = m_stable;
      clr = SwitchCtrl && ioRead && (swAddr == 2'b00);
      m_pulse = 0;
      if (s != m_level) begin
         m_run++;
         if (m_run == DEB + 1) begin
            m_level = s;
            m_run   = 0;
            if (s) m_pulse = 1;
         end
      end else begin
         m_run = 0;
      end
      if (sv == m_last) begin
         if (m_srun < 1000) m_srun++;
      end else begin
         m_last = sv;
         m_srun = 1;
      end
      if (m_srun >= DEB + 1) m_stable = m_last;
      if (old_pulse) begin
         m_snap  = old_stable;
         m_valid = 1;
      end else if (clr) begin
         m_valid = 0;
      end
   endtask

   function automatic logic [15:0] model_rd();
      if (!(SwitchCtrl && ioRead)) return 16'h0000;
      case (swAddr)
         2'b00, 2'b01: return m_snap[15:0];
         2'b10:        return {8'h00, m_snap[23:16]};
         default:      return {15'b0, m_valid};
      endcase
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clock);
         model_step();
         #1;
         chk("model_submit", {31'b0, submit}, {31'b0, m_level});
         chk("model_pulse", {31'b0, submit_pulse}, {31'b0, m_pulse});
         chk("model_valid", {31'b0, sw_valid}, {31'b0, m_valid});
         chk("model_read_data", {16'b0, read_data}, {16'b0, model_rd()});
      end
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic reads_off();
      SwitchCtrl = 0; ioRead = 0; swAddr = 2'b00;
   endtask

   int  hold_cnt;
   int  rst_cnt;
   bit  got;

   initial begin
      reset_n = 1; sw_raw = 0; submit_raw = 0;
      reads_off();
      #1 reset_n = 0;
      SwitchCtrl = 1; ioRead = 1; swAddr = 2'b11;
      edges(2);
      chk("reset_submit", {31'b0, submit}, 0);
      chk("reset_pulse", {31'b0, submit_pulse}, 0);
      chk("reset_valid", {31'b0, sw_valid}, 0);
      chk("reset_read", {16'b0, read_data}, 0);

      // Button held and switches stable from before the first edge.
      @(negedge clock);
      reads_off();
      submit_raw = 1; sw_raw = 24'hA5C3F0;
      @(negedge clock) reset_n = 1;
      edges(6);
      chk("rise_edge6_submit", {31'b0, submit}, 0);
      chk("rise_edge6_pulse", {31'b0, submit_pulse}, 0);
      edges(1);
      chk("rise_edge7_submit", {31'b0, submit}, 1);
      chk("rise_edge7_pulse", {31'b0, submit_pulse}, 1);
      edges(1);
      chk("rise_edge8_pulse", {31'b0, submit_pulse}, 0);
      chk("rise_edge8_submit", {31'b0, submit}, 1);
      chk("snap_valid", {31'b0, sw_valid}, 1);
      @(negedge clock);
      SwitchCtrl = 1; ioRead = 1; swAddr = 2'b10;
      #1 chk("read_hi", {16'b0, read_data}, 32'h00A5);
      swAddr = 2'b11;
      #1 chk("read_stat", {16'b0, read_data}, 32'h0001);
      swAddr = 2'b01;
      #1 chk("read_lo_alt", {16'b0, read_data}, 32'hC3F0);
      swAddr = 2'b00;
      #1 chk("read_lo", {16'b0, read_data}, 32'hC3F0);
      edges(1);
      chk("read_clears_valid", {31'b0, sw_valid}, 0);
      @(negedge clock) reads_off();

      // Short release while held: no change, no second pulse.
      @(negedge clock) submit_raw = 0;
      @(negedge clock);
      @(negedge clock) submit_raw = 1;
      repeat (15) begin
         edges(1);
         chk("glitch_submit", {31'b0, submit}, 1);
         chk("glitch_pulse", {31'b0, submit_pulse}, 0);
      end
      @(negedge clock) submit_raw = 0;
      edges(10);
      chk("release_submit", {31'b0, submit}, 0);

      // Three-cycle press is rejected.
      @(negedge clock) submit_raw = 1;
      @(negedge clock);
      @(negedge clock);
      @(negedge clock) submit_raw = 0;
      repeat (12) begin
         edges(1);
         chk("short_submit", {31'b0, submit}, 0);
         chk("short_pulse", {31'b0, submit_pulse}, 0);
      end

      // Consuming read on the same edge as the capture.
      @(negedge clock) sw_raw = 24'h123456;
      edges(8);
      @(negedge clock) submit_raw = 1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         edges(1);
         if (submit_pulse) got = 1;
      end
      chk("pulse_seen", {31'b0, got}, 1);
      @(negedge clock);
      SwitchCtrl = 1; ioRead = 1; swAddr = 2'b00;
      edges(1);
      chk("set_wins_valid", {31'b0, sw_valid}, 1);
      chk("set_wins_read", {16'b0, read_data}, 32'h3456);
      edges(1);
      chk("second_read_clears", {31'b0, sw_valid}, 0);
      @(negedge clock) begin reads_off(); submit_raw = 0; end
      edges(10);

      // Reset in the middle of a debounce count.
      @(negedge clock) submit_raw = 1;
      edges(10);
      chk("pre_rst_valid", {31'b0, sw_valid}, 1);
      @(negedge clock) submit_raw = 0;
      edges(10);
      @(negedge clock) submit_raw = 1;
      edges(4);
      #1;
      reset_n = 0;
      SwitchCtrl = 1; ioRead = 1; swAddr = 2'b11;
      #1;
      chk("async_rst_submit", {31'b0, submit}, 0);
      chk("async_rst_pulse", {31'b0, submit_pulse}, 0);
      chk("async_rst_valid", {31'b0, sw_valid}, 0);
      chk("async_rst_read", {16'b0, read_data}, 0);
      edges(2);
      @(negedge clock) begin reset_n = 1; reads_off(); end
      edges(6);
      chk("post_rst_edge6", {31'b0, submit}, 0);
      edges(1);
      chk("post_rst_edge7", {31'b0, submit}, 1);

      // Randomized traffic.
      hold_cnt = 0;
      rst_cnt  = 0;
      repeat (2000) begin
         @(negedge clock);
         if (hold_cnt == 0) begin
            submit_raw = 1'($urandom_range(0, 1));
            hold_cnt   = $urandom_range(1, 12);
         end else begin
            hold_cnt--;
         end
         if ($urandom_range(0, 15) == 0) sw_raw = 24'($urandom);
         SwitchCtrl = 1'($urandom_range(0, 1));
         ioRead     = 1'($urandom_range(0, 1));
         swAddr     = 2'($urandom_range(0, 3));
         if (rst_cnt > 0) begin
            rst_cnt--;
            if (rst_cnt == 0) reset_n = 1;
         end else if ($urandom_range(0, 399) == 0) begin
            reset_n = 0;
            rst_cnt = $urandom_range(1, 2);
         end
      end
      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
